tone_sequencer: RTL and testbench
=================================

Name: tone_sequencer

Overview:
- Melody engine that drives the 1-bit `speaker` square wave consumed by the audio mixing stage. That stage converts the bit into a ±amplitude sample, gated by an enable.
- Walks a song stored in an external synchronous ROM. Each entry is a pitch plus a duration.
- Per note: produces a square wave at the note frequency for the entry's duration, then a short silent articulation gap.
- Start/stop controlled by game logic; signals completion with a one-cycle `done` pulse.

Parameters:
- CLK_FREQ, 50000000, input clock frequency in Hz; half-period divisors derive from it.
- TEMPO_TICKS, 6250000, clock cycles per duration unit (default 1/8 s).
- GAP_TICKS, 500000, silent cycles after each note; 0 = no gap.
- ADDR_W, 6, ROM address width (max 2**ADDR_W entries).

Ports:
- CLOCK_50, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse; begins playback at address 0 when idle.
- stop, in, 1, one-cycle pulse; aborts playback.
- loop, in, 1, restart at song end (honoured only with the optional feature).
- rom_addr, out, ADDR_W, song ROM address.
- rom_data, in, 9, ROM word {pitch[8:4], dur[3:0]}; valid 1 cycle after rom_addr.
- speaker, out, 1, square-wave output.
- busy, out, 1, high from the cycle after accepted start until IDLE.
- note_idx, out, 5, pitch currently playing (0 = rest/idle).
- done, out, 1, one-cycle pulse on normal song end.

Behaviour:
- Reset (async, any state): state IDLE; rom_addr=0, speaker=0, busy=0, note_idx=0, done=0; all counters 0.
- States: IDLE, FETCH, WAIT, PLAY, GAP, DONE.
- IDLE: on start → FETCH with rom_addr=0, busy=1.
- FETCH: holds rom_addr for 1 cycle → WAIT.
- WAIT: samples rom_data, then decodes:
  - dur==0 → DONE (end marker).
  - otherwise → PLAY: load note_idx=pitch, dur counter=dur*TEMPO_TICKS, speaker=0, half-period counter cleared.
- Start latency: start sampled at cycle 0 → PLAY begins at cycle 3.
- Pitch mapping: 1..12 = C4..B4, 13..24 = C5..B5. Integer Hz: 262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494, 523, 554, 587, 622, 659, 698, 740, 784, 831, 880, 932, 988.
  - half_period = CLK_FREQ/(2*f), truncated, computed at elaboration.
- Rest: pitch 0 or pitch >24. speaker held 0 and note_idx=0 for the duration.
- PLAY:
  - speaker toggles every half_period cycles; first toggle half_period cycles after PLAY entry.
  - Lasts exactly dur*TEMPO_TICKS cycles; then speaker=0, note_idx=0, → GAP (or directly to advance if GAP_TICKS==0).
- GAP: GAP_TICKS cycles silent. Then advance:
  - rom_addr == 2**ADDR_W-1 → DONE (address never wraps).
  - otherwise rom_addr+1, → FETCH.
- DONE: done=1 for exactly one cycle, busy=0, rom_addr=0 → IDLE.
- stop in any non-IDLE state (including the same cycle as an advance) → IDLE next cycle: speaker=0, busy=0, note_idx=0, no done pulse. stop has priority over all other transitions.
- start while busy: ignored. start and stop in the same cycle while IDLE: stop wins, remain IDLE.
- Counter widths: sized for dur max 15 * TEMPO_TICKS; no overflow permitted.

Optional Feature:
- Macro: TONE_SEQ_LOOP_EN.
- Defined: at song end (end marker or last address), if loop==1 then skip DONE and no done pulse; rom_addr=0 → FETCH, busy stays 1. loop==0 behaves as normal end.
- Undefined: loop port present but ignored; always ends via DONE.

Test Plan (CLK_FREQ=8800, TEMPO_TICKS=100, GAP_TICKS=4, ADDR_W=3):
- ROM {A4 (10), dur 2}, {end}; pulse start → PLAY at cycle 3, note_idx=10, speaker toggles every 10 cycles (20 edges over 200 cycles), 4 silent cycles, done pulse once, busy low.
- ROM {pitch 0, dur 1}, {end} → speaker 0 and note_idx 0 for 100 cycles, then done.
- ROM end marker at address 0 → done pulse 3 cycles after start, speaker never toggles.
- stop 50 cycles into an A4 note → next cycle speaker=0, busy=0, note_idx=0; done never pulses.
- 8 entries, all dur 1 → rom_addr steps 0..7, done after entry 7, rom_addr returns 0 (no wrap replay).
- reset_n low mid-PLAY → all outputs 0 immediately, without waiting for a clock edge. With TONE_SEQ_LOOP_EN and loop=1: after the end marker, rom_addr returns to 0 and the first note replays, with no done pulse.

Source files
------------

// File: rtl/tone_sequencer.sv
// tone_sequencer: walks a song ROM and plays each {pitch,dur} entry as a square wave on speaker.
// Optional macro TONE_SEQ_LOOP_EN: at song end with loop high, replay from address 0 instead of DONE.
module tone_sequencer #(
  parameter int CLK_FREQ    = 50000000,
  parameter int TEMPO_TICKS = 6250000,
  parameter int GAP_TICKS   = 500000,
  parameter int ADDR_W      = 6
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [8:0]        rom_data,
  output logic              speaker,
  output logic              busy,
  output logic [4:0]        note_idx,
  output logic              done
);
  localparam int HW = $clog2(CLK_FREQ / 524 + 1);
  localparam int DW = $clog2(15 * TEMPO_TICKS + 1);
  localparam int GW = $clog2(GAP_TICKS + 2);
  localparam int FREQ [32] = '{1, 262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494,
                               523, 554, 587, 622, 659, 698, 740, 784, 831, 880, 932, 988,
                               1, 1, 1, 1, 1, 1, 1};
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PLAY, GAP, DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0]     dur_q, dur_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              spk_q, spk_d;
  logic [4:0]        note_q, note_d;
  logic [HW-1:0]     hp_rom [32];
  logic [4:0]        pitch;
  logic [3:0]        dur;
  logic              abort, play_end, gap_end, advance, song_end, relaunch;
  for (genvar i = 0; i < 32; i++) begin : g_hp
    assign hp_rom[i] = (i >= 1 && i <= 24) ? HW'(CLK_FREQ / (2 * FREQ[i])) : '0;
  end
  assign pitch    = rom_data[8:4];
  assign dur      = rom_data[3:0];
  assign abort    = stop && state_q != IDLE;
  assign play_end = state_q == PLAY && dur_q <= DW'(1);
  assign gap_end  = state_q == GAP && gap_q <= GW'(1);
  assign advance  = (play_end && GAP_TICKS == 0) || gap_end;
  assign song_end = (state_q == WAIT && dur == 4'd0) || (advance && addr_q == '1);
`ifdef TONE_SEQ_LOOP_EN
  assign relaunch = loop;
`else
  assign relaunch = 1'b0 & loop;
`endif
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    case (state_q)
      IDLE:    state_d = (start && !stop) ? FETCH : IDLE;
      FETCH:   state_d = WAIT;
      WAIT:    state_d = PLAY;
      PLAY:    state_d = play_end ? GAP : PLAY;
      DONE:    state_d = IDLE;
      default: state_d = state_q;
    endcase
    if (advance) state_d = FETCH;
    if (song_end) state_d = relaunch ? FETCH : DONE;
    if (abort) state_d = IDLE;
  end
  always_comb begin
    busy = state_q != IDLE && state_q != DONE;
    done = state_q == DONE;
  end
  // Datapath: note load on WAIT, tone/duration counting in PLAY, address stepping on advance
  always_comb begin
    addr_d = addr_q;
    dur_d  = dur_q;
    hcnt_d = hcnt_q;
    gap_d  = gap_q;
    spk_d  = spk_q;
    note_d = note_q;
    if (state_q == WAIT && dur != 4'd0) begin
      note_d = (pitch <= 5'd24) ? pitch : 5'd0;
      dur_d  = DW'(dur * TEMPO_TICKS);
      hcnt_d = '0;
      spk_d  = 1'b0;
    end
    if (state_q == PLAY) begin
      dur_d  = dur_q - DW'(1);
      hcnt_d = hcnt_q + HW'(1);
      if (note_q != 5'd0 && hcnt_q == hp_rom[note_q] - HW'(1)) begin
        hcnt_d = '0;
        spk_d  = ~spk_q;
      end
    end
    if (play_end) begin
      spk_d  = 1'b0;
      note_d = 5'd0;
      gap_d  = GW'(GAP_TICKS);
    end
    if (state_q == GAP) gap_d = gap_q - GW'(1);
    if (advance) addr_d = addr_q + ADDR_W'(1);
    if (song_end || abort) addr_d = '0;
    if (abort) begin
      spk_d  = 1'b0;
      note_d = 5'd0;
    end
  end
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      dur_q  <= '0;
      hcnt_q <= '0;
      gap_q  <= '0;
      spk_q  <= 1'b0;
      note_q <= 5'd0;
    end else begin
      addr_q <= addr_d;
      dur_q  <= dur_d;
      hcnt_q <= hcnt_d;
      gap_q  <= gap_d;
      spk_q  <= spk_d;
      note_q <= note_d;
    end
  end
  assign rom_addr = addr_q;
  assign speaker  = spk_q;
  assign note_idx = note_q;
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: directed checks of tone_sequencer with a small clock and tempo.
module tb_tone_sequencer;
  localparam int ADDR_W = 3;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              loop = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [8:0]        rom_data;
  logic              speaker, busy, done;
  logic [4:0]        note_idx;
  logic [8:0]        rom [8];
  int                errors = 0;
  int                checks = 0;
  tone_sequencer #(
    .CLK_FREQ(8800), .TEMPO_TICKS(100), .GAP_TICKS(4), .ADDR_W(ADDR_W)
  ) dut (
    .CLOCK_50(clk), .reset_n(rst_n), .start(start), .stop(stop), .loop(loop),
    .rom_addr(rom_addr), .rom_data(rom_data), .speaker(speaker), .busy(busy),
    .note_idx(note_idx), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask
  function automatic logic [8:0] ent(input int p, input int d);
    return {5'(p), 4'(d)};
  endfunction
  initial begin
    int   edges;
    logic prev, seen;
    int   pit [8] = '{1, 5, 10, 13, 24, 25, 31, 12};
    int   exp_note [8] = '{1, 5, 10, 13, 24, 0, 0, 12};
    for (int i = 0; i < 8; i++) rom[i] = '0;
    tick(2);
    check("rst_speaker", speaker, 0);
    check("rst_busy", busy, 0);
    check("rst_note", note_idx, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    tick(2);
    // A4 for two units, then end marker
    rom[0] = ent(10, 2);
    rom[1] = ent(0, 0);
    pulse_start();
    check("t1_busy_fetch", busy, 1);
    tick(1);
    check("t1_note_wait", note_idx, 0);
    tick(1);
    check("t1_note_play", note_idx, 10);
    check("t1_spk_play", speaker, 0);
    edges = 0;
    prev = speaker;
    for (int i = 1; i <= 200; i++) begin
      tick(1);
      if (speaker !== prev) edges++;
      prev = speaker;
      if (i == 9) check("t1_pre_toggle", speaker, 0);
      if (i == 10) check("t1_first_toggle", speaker, 1);
      if (i == 100) check("t1_note_mid", note_idx, 10);
      start = (i == 50);
    end
    check("t1_edges", edges, 20);
    check("t1_gap_spk", speaker, 0);
    check("t1_gap_note", note_idx, 0);
    check("t1_gap_busy", busy, 1);
    tick(3);
    check("t1_addr_gap", rom_addr, 0);
    tick(1);
    check("t1_addr_next", rom_addr, 1);
    tick(2);
    check("t1_done", done, 1);
    check("t1_done_busy", busy, 0);
    check("t1_done_addr", rom_addr, 0);
    tick(1);
    check("t1_done_once", done, 0);
    // rest note
    rom[0] = ent(0, 1);
    pulse_start();
    tick(2);
    check("t2_note", note_idx, 0);
    check("t2_busy", busy, 1);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      seen = seen | speaker | (note_idx != 0);
      tick(1);
    end
    check("t2_silent", seen, 0);
    tick(6);
    check("t2_done", done, 1);
    tick(1);
    // end marker at address 0
    rom[0] = ent(0, 0);
    pulse_start();
    check("t3_done_c1", done, 0);
    tick(1);
    check("t3_done_c2", done, 0);
    tick(1);
    check("t3_done_c3", done, 1);
    check("t3_spk", speaker, 0);
    tick(1);
    check("t3_done_c4", done, 0);
    // stop mid-note
    rom[0] = ent(10, 2);
    pulse_start();
    tick(52);
    check("t4_spk_before", speaker, 1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("t4_spk", speaker, 0);
    check("t4_busy", busy, 0);
    check("t4_note", note_idx, 0);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      seen = seen | done;
      tick(1);
    end
    check("t4_no_done", seen, 0);
    start = 1'b1;
    stop = 1'b1;
    tick(1);
    start = 1'b0;
    stop = 1'b0;
    check("t4_start_stop_idle", busy, 0);
    // eight one-unit entries, including out-of-range pitches
    for (int i = 0; i < 8; i++) rom[i] = ent(pit[i], 1);
    pulse_start();
    seen = 1'b0;
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      if ((cyc - 1) % 106 == 0 && cyc <= 743) check("t5_addr", rom_addr, (cyc - 1) / 106);
      if (cyc >= 3 && (cyc - 3) % 106 == 0 && cyc <= 745) check("t5_note", note_idx, exp_note[(cyc - 3) / 106]);
      if (cyc == 18 || cyc == 430) check("t5_spk_pre", speaker, 0);
      if (cyc == 19 || cyc == 431) check("t5_spk_toggle", speaker, 1);
      if (cyc == 848) check("t5_done_early", done, 0);
      if (cyc == 849) check("t5_done", done, 1);
      if (cyc == 849) check("t5_done_addr", rom_addr, 0);
      if (cyc == 850) check("t5_idle", busy, 0);
      if (cyc > 850) seen = seen | busy | (rom_addr != 0);
      tick(1);
    end
    check("t5_no_replay", seen, 0);
    // async reset mid-note
    rom[0] = ent(10, 2);
    rom[1] = ent(0, 0);
    pulse_start();
    tick(17);
    check("t6_spk_before", speaker, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_spk", speaker, 0);
    check("t6_busy", busy, 0);
    check("t6_note", note_idx, 0);
    check("t6_addr", rom_addr, 0);
    check("t6_done", done, 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    loop = 1'b1;
`ifdef TONE_SEQ_LOOP_EN
    rom[0] = ent(10, 1);
    rom[1] = ent(0, 0);
    pulse_start();
    seen = 1'b0;
    for (int i = 1; i <= 110; i++) begin
      seen = seen | done;
      if (i == 107) check("t7_addr_end", rom_addr, 1);
      if (i == 109) check("t7_addr_wrap", rom_addr, 0);
      if (i == 109) check("t7_busy", busy, 1);
      tick(1);
    end
    check("t7_no_done", seen, 0);
    check("t7_replay_note", note_idx, 10);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("t7_stopped", busy, 0);
`else
    rom[0] = ent(0, 0);
    pulse_start();
    tick(2);
    check("t7_loop_ignored", done, 1);
    tick(1);
`endif
    loop = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
